// File: rtl/rsign_ctrl.sv
// Control for the RSign binariser array: serial threshold loading into a shadow bank,
// commits between frames only, window gating and latency-aligned valid / frame_done.
module rsign_ctrl #(
    parameter int unsigned FM_DEPTH   = 64,
    parameter int unsigned PARA_WIDTH = 16,
    parameter int unsigned FM_SIZE    = 784,
    parameter int unsigned RSIGN_LAT  = 1
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 para_s_valid,
    input  logic [PARA_WIDTH-1:0]                para_s_data,
    output logic                                 para_s_ready,
    input  logic                                 win_valid,
    output logic                                 in_ready,
    output logic                                 rsign_valid,
    output logic [FM_DEPTH-1:0][PARA_WIDTH-1:0]  para_out,
    output logic                                 out_valid,
    output logic                                 frame_done,
    output logic                                 para_loaded,
    output logic [$clog2(FM_SIZE+1)-1:0]         win_cnt
);

    localparam int unsigned IdxW = (FM_DEPTH > 1) ? $clog2(FM_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FM_SIZE + 1);

    typedef enum logic [1:0] {StIdle, StReady, StRun, StDrain} state_e;

    state_e                               state_q, state_d;
    logic [IdxW-1:0]                      idx_q;
    logic                                 shadow_full_q;
    logic [FM_DEPTH-1:0][PARA_WIDTH-1:0]  shadow_q;
    logic [FM_DEPTH-1:0][PARA_WIDTH-1:0]  active_q;
    logic                                 para_loaded_q;
    logic [CntW-1:0]                      win_cnt_q, win_cnt_d;
    logic [RSIGN_LAT-1:0]                 vld_pipe_q, vld_pipe_d;
    logic [RSIGN_LAT-1:0]                 last_pipe_q, last_pipe_d;
    logic                                 beat, accept, last_acc, commit;

    assign para_s_ready = ~shadow_full_q;
    assign beat         = para_s_valid & ~shadow_full_q;
    assign accept       = win_valid & in_ready;
    assign rsign_valid  = accept;
    assign out_valid    = vld_pipe_q[RSIGN_LAT-1];
    assign frame_done   = out_valid & last_pipe_q[RSIGN_LAT-1];
    assign para_out     = active_q;
    assign para_loaded  = para_loaded_q;
    assign win_cnt      = win_cnt_q;

    // A pending set is only committed while no frame is in flight.
    assign commit = shadow_full_q &
                    ((state_q == StIdle) | (state_q == StReady) |
                     ((state_q == StDrain) & frame_done));

    assign last_acc = accept & ((state_q == StReady) ? (FM_SIZE == 1)
                                                     : (win_cnt_q == CntW'(FM_SIZE - 1)));

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (commit) state_d = StReady;
            StReady: if (accept) state_d = (FM_SIZE == 1) ? StDrain : StRun;
            StRun:   if (last_acc) state_d = StDrain;
            StDrain: if (frame_done) state_d = StReady;
            default: state_d = StIdle;
        endcase
    end

    // Output logic; in READY a full shadow bank blocks frame start so the commit wins
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            StIdle:  in_ready = 1'b0;
            StReady: in_ready = ~shadow_full_q;
            StRun:   in_ready = 1'b1;
            StDrain: in_ready = 1'b0;
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q         <= '0;
            shadow_full_q <= 1'b0;
            shadow_q      <= '0;
        end else if (beat) begin
            shadow_q[idx_q] <= para_s_data;
            if (idx_q == IdxW'(FM_DEPTH - 1)) begin
                idx_q         <= '0;
                shadow_full_q <= 1'b1;
            end else begin
                idx_q <= idx_q + IdxW'(1);
            end
        end else if (commit) begin
            shadow_full_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            active_q      <= '0;
            para_loaded_q <= 1'b0;
        end else if (commit) begin
            active_q      <= shadow_q;
            para_loaded_q <= 1'b1;
        end
    end

    always_comb begin
        win_cnt_d = win_cnt_q;
        if ((state_q == StDrain) && frame_done) begin
            win_cnt_d = '0;
        end else if (accept) begin
            win_cnt_d = (state_q == StReady) ? CntW'(1) : win_cnt_q + CntW'(1);
        end
    end

    always_comb begin
        vld_pipe_d     = vld_pipe_q;
        last_pipe_d    = last_pipe_q;
        vld_pipe_d[0]  = accept;
        last_pipe_d[0] = last_acc;
        for (int i = 1; i < RSIGN_LAT; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            last_pipe_d[i] = last_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_cnt_q   <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
        end else begin
            win_cnt_q   <= win_cnt_d;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
        end
    end

endmodule

// File: tb/tb_rsign_ctrl.sv
// Bench for rsign_ctrl: directed scenarios plus random traffic, checked every cycle
// against a behavioural model of load / commit / frame rules.
module tb_rsign_ctrl;

    localparam int unsigned FM_DEPTH   = 64;
    localparam int unsigned PARA_WIDTH = 16;
    localparam int unsigned FM_SIZE    = 4;
    localparam int unsigned RSIGN_LAT  = 2;
    localparam int unsigned CW         = $clog2(FM_SIZE + 1);

    logic                                clk = 1'b0;
    logic                                rstn = 1'b0;
    logic                                para_s_valid = 1'b0;
    logic [PARA_WIDTH-1:0]               para_s_data = '0;
    logic                                para_s_ready;
    logic                                win_valid = 1'b0;
    logic                                in_ready;
    logic                                rsign_valid;
    logic [FM_DEPTH-1:0][PARA_WIDTH-1:0] para_out;
    logic                                out_valid;
    logic                                frame_done;
    logic                                para_loaded;
    logic [CW-1:0]                       win_cnt;

    rsign_ctrl #(
        .FM_DEPTH  (FM_DEPTH),
        .PARA_WIDTH(PARA_WIDTH),
        .FM_SIZE   (FM_SIZE),
        .RSIGN_LAT (RSIGN_LAT)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .para_s_valid(para_s_valid),
        .para_s_data (para_s_data),
        .para_s_ready(para_s_ready),
        .win_valid   (win_valid),
        .in_ready    (in_ready),
        .rsign_valid (rsign_valid),
        .para_out    (para_out),
        .out_valid   (out_valid),
        .frame_done  (frame_done),
        .para_loaded (para_loaded),
        .win_cnt     (win_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: shadow beats as a queue, frame progress as a window count, and the
    // cycle index of every accepted window (out_valid is exactly RSIGN_LAT later).
    int  sh_q[$];
    int  active[FM_DEPTH];
    bit  loaded;
    int  cnt;
    int  cyc = 0;
    bit  acc_at[int];
    bit  last_at[int];

    function automatic bit m_full();
        return sh_q.size() == FM_DEPTH;
    endfunction

    function automatic bit m_in_ready();
        if (!loaded) return 1'b0;
        if (cnt == 0) return !m_full();
        return cnt < FM_SIZE;
    endfunction

    function automatic bit m_out_valid();
        return acc_at.exists(cyc - RSIGN_LAT);
    endfunction

    function automatic bit m_frame_done();
        return acc_at.exists(cyc - RSIGN_LAT) && last_at[cyc - RSIGN_LAT];
    endfunction

    task automatic m_reset();
        sh_q.delete();
        foreach (active[k]) active[k] = 0;
        loaded = 1'b0;
        cnt    = 0;
        acc_at.delete();
        last_at.delete();
    endtask

    task automatic m_step();
        bit full   = m_full();
        bit acc    = win_valid && m_in_ready();
        bit fd     = m_frame_done();
        bit commit = full && (cnt == 0 || fd);
        if (fd) cnt = 0;
        if (acc) begin
            cnt++;
            acc_at[cyc]  = 1'b1;
            last_at[cyc] = (cnt == FM_SIZE);
        end
        if (commit) begin
            foreach (active[k]) active[k] = sh_q[k];
            sh_q.delete();
            loaded = 1'b1;
        end else if (para_s_valid && !full) begin
            sh_q.push_back(int'(para_s_data));
        end
        cyc++;
    endtask

    task automatic m_compare();
        logic [FM_DEPTH-1:0][PARA_WIDTH-1:0] ev;
        foreach (active[k]) ev[k] = active[k][PARA_WIDTH-1:0];
        chk("para_s_ready", 64'(para_s_ready), 64'(!m_full()));
        chk("in_ready", 64'(in_ready), 64'(m_in_ready()));
        chk("rsign_valid", 64'(rsign_valid), 64'(win_valid && m_in_ready()));
        chk("out_valid", 64'(out_valid), 64'(m_out_valid()));
        chk("frame_done", 64'(frame_done), 64'(m_frame_done()));
        chk("para_loaded", 64'(para_loaded), 64'(loaded));
        chk("win_cnt", 64'(win_cnt), 64'(cnt));
        n_checks++;
        if (para_out !== ev) begin
            n_fail++;
            for (int k = 0; k < FM_DEPTH; k++) begin
                if (para_out[k] !== ev[k]) begin
                    $display("FAIL para_out[%0d]: got %0h, expected %0h (t=%0t)",
                             k, para_out[k], ev[k], $time);
                    break;
                end
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(negedge clk);
            if (!rstn) m_reset();
            m_compare();
            @(posedge clk);
            if (rstn) m_step();
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stream_set(input int base, input int step);
        for (int k = 0; k < FM_DEPTH; k++) begin
            para_s_valid = 1'b1;
            para_s_data  = PARA_WIDTH'(base + step * k);
            tick();
        end
        para_s_valid = 1'b0;
    endtask

    task automatic wait_frame_done(input string name, output int at_cyc);
        bit seen = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) begin
                seen   = 1'b1;
                at_cyc = cyc;
            end else begin
                tick();
            end
        end
        if (!seen) chk(name, 64'd0, 64'd1);
    endtask

    initial begin
        int acc_n, last_cyc, fd_cyc, guard;

        // Reset values
        rstn = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_para_s_ready", 64'(para_s_ready), 64'd1);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_para_loaded", 64'(para_loaded), 64'd0);
        chk("rst_para_out", 64'(para_out[0] | para_out[FM_DEPTH-1]), 64'd0);
        tick();
        rstn = 1'b1;
        tick();

        // Windows before any load are ignored
        win_valid = 1'b1;
        repeat (5) begin
            tick();
            @(negedge clk);
            chk("noload_in_ready", 64'(in_ready), 64'd0);
            chk("noload_rsign_valid", 64'(rsign_valid), 64'd0);
            chk("noload_win_cnt", 64'(win_cnt), 64'd0);
        end
        tick();
        win_valid = 1'b0;

        // First load, data = 3k; committed from IDLE the cycle after the bank fills
        stream_set(0, 3);
        tick();
        @(negedge clk);
        chk("load_para_loaded", 64'(para_loaded), 64'd1);
        chk("load_para_s_ready", 64'(para_s_ready), 64'd1);
        chk("load_in_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < FM_DEPTH; k++) chk("load_para_out", 64'(para_out[k]), 64'(3 * k));
        tick();

        // Frame with 1-cycle gaps between windows
        acc_n = 0;
        last_cyc = 0;
        for (int i = 0; i < 20 && acc_n < FM_SIZE; i++) begin
            win_valid = 1'b1;
            @(negedge clk);
            if (rsign_valid) begin
                acc_n++;
                last_cyc = cyc;
            end
            tick();
            win_valid = 1'b0;
            tick();
        end
        chk("gap_accepts", 64'(acc_n), 64'(FM_SIZE));
        wait_frame_done("gap_frame_done_seen", fd_cyc);
        chk("gap_frame_done_lat", 64'(fd_cyc - last_cyc), 64'(RSIGN_LAT));
        tick();

        // New set streamed mid-frame waits for the frame end
        win_valid = 1'b1;
        tick();
        win_valid = 1'b0;
        stream_set(256, 1);
        tick();
        @(negedge clk);
        chk("mid_para_s_ready", 64'(para_s_ready), 64'd0);
        chk("mid_para_out_old", 64'(para_out[5]), 64'd15);
        tick();
        win_valid = 1'b1;
        repeat (FM_SIZE - 1) tick();
        win_valid = 1'b0;
        wait_frame_done("mid_frame_done_seen", fd_cyc);
        chk("mid_para_out_at_fd", 64'(para_out[5]), 64'd15);
        tick();
        @(negedge clk);
        chk("mid_para_s_ready_after", 64'(para_s_ready), 64'd1);
        for (int k = 0; k < FM_DEPTH; k++) chk("mid_para_out_new", 64'(para_out[k]), 64'(256 + k));
        tick();

        // win_valid held high across frames
        win_valid = 1'b1;
        acc_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsign_valid) acc_n++;
            if (frame_done) begin
                chk("held_accepts_per_frame", 64'(acc_n), 64'(FM_SIZE));
                acc_n = 0;
            end
            tick();
        end

        // Reset in the middle of a frame at win_cnt = 2
        guard = 0;
        while (guard < 20) begin
            @(negedge clk);
            if (win_cnt == CW'(2)) break;
            tick();
            guard++;
        end
        chk("mid_rst_reached_cnt2", 64'(win_cnt), 64'd2);
        win_valid = 1'b0;
        tick();
        rstn = 1'b0;
        @(negedge clk);
        chk("mid_rst_para_out", 64'(para_out == '0), 64'd1);
        chk("mid_rst_para_loaded", 64'(para_loaded), 64'd0);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_win_cnt", 64'(win_cnt), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        rstn = 1'b1;
        tick();

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            win_valid    = ($urandom_range(0, 9) < 6);
            para_s_valid = ($urandom_range(0, 3) == 0);
            para_s_data  = PARA_WIDTH'($urandom);
            tick();
        end
        win_valid    = 1'b0;
        para_s_valid = 1'b0;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
